// File: rtl/mul_share_arbiter_if.sv
// Requester-side and multiplier-side signals of mul_share_arbiter.
// The arbiter connects through the slave modport and the environment through the master modport.
interface mul_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       iReq;
    logic [NUM_REQ*WIDTH-1:0] iA;
    logic [NUM_REQ*WIDTH-1:0] iB;
    logic [NUM_REQ-1:0]       iUnscaled;
    logic [NUM_REQ-1:0]       oGrant;
    logic [NUM_REQ-1:0]       oDone;
    logic                     oError;
    logic [2*WIDTH-1:0]       oResult;
    logic                     oBusy;
    logic [WIDTH-1:0]         oMulA;
    logic [WIDTH-1:0]         oMulB;
    logic                     oMulUnscaled;
    logic                     oMulInputReady;
    logic [2*WIDTH-1:0]       iMulR;
    logic                     iMulOutputReady;

    modport slave (
        input  iReq, iA, iB, iUnscaled, iMulR, iMulOutputReady,
        output oGrant, oDone, oError, oResult, oBusy,
               oMulA, oMulB, oMulUnscaled, oMulInputReady
    );

    modport master (
        output iReq, iA, iB, iUnscaled, iMulR, iMulOutputReady,
        input  oGrant, oDone, oError, oResult, oBusy,
               oMulA, oMulB, oMulUnscaled, oMulInputReady
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one multiplier among NUM_REQ requesters.
// One op in flight: IDLE -> ISSUE -> WAIT -> DONE, with a watchdog on the multiplier reply.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               Clock,
    input  logic               Reset,
    mul_share_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(NUM_REQ);
    localparam int WDW  = $clog2(TIMEOUT + 1);
    localparam logic [IDXW:0]        NREQ_W    = (IDXW + 1)'(NUM_REQ);
    localparam logic [WDW-1:0]       WD_MAX    = WDW'(TIMEOUT);
    localparam logic [NUM_REQ-1:0]   GRANT_LSB = NUM_REQ'(1);

    typedef enum logic [1:0] {
        sIdle  = 2'd0,
        sIssue = 2'd1,
        sWait  = 2'd2,
        sDone  = 2'd3
    } stateT;

    stateT              stateR;
    stateT              nextStateS;
    logic [IDXW-1:0]    ptrR;
    logic [IDXW-1:0]    ownerR;
    logic [IDXW-1:0]    pickS;
    logic               reqAnyS;
    logic [WDW-1:0]     wdR;
    logic               wdExpiredS;
    logic [NUM_REQ-1:0] grantR;
    logic [NUM_REQ-1:0] doneR;
    logic               errorR;
    logic [2*WIDTH-1:0] resultR;
    logic               busyR;
    logic [WIDTH-1:0]   mulAR;
    logic [WIDTH-1:0]   mulBR;
    logic               mulUnscaledR;
    logic               mulInputReadyR;

    // (base + off) mod NUM_REQ without a divider; base + off never exceeds 2*NUM_REQ-2.
    function automatic logic [IDXW-1:0] rotIdx(input logic [IDXW-1:0] base, input logic [IDXW:0] off);
        logic [IDXW:0] raw;
        raw = {1'b0, base} + off;
        raw = (raw >= NREQ_W) ? (raw - NREQ_W) : raw;
        return raw[IDXW-1:0];
    endfunction

    // State register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            stateR <= sIdle;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Next-state logic and round-robin pick; scanning downward lets the nearest requester win.
    always_comb begin
        nextStateS = stateR;
        pickS      = ptrR;
        reqAnyS    = |bus.iReq;
        wdExpiredS = (wdR == WD_MAX);
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            pickS = bus.iReq[rotIdx(ptrR, (IDXW + 1)'(off))] ? rotIdx(ptrR, (IDXW + 1)'(off)) : pickS;
        end
        case (stateR)
            sIdle: begin
                if (reqAnyS) begin
                    nextStateS = sIssue;
                end else begin
                    nextStateS = sIdle;
                end
            end
            sIssue: nextStateS = sWait;
            sWait: begin
                if (bus.iMulOutputReady || wdExpiredS) begin
                    nextStateS = sDone;
                end else begin
                    nextStateS = sWait;
                end
            end
            sDone:   nextStateS = sIdle;
            default: nextStateS = sIdle;
        endcase
    end

    // Registered datapath and outputs; pulses default low every cycle.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ptrR           <= '0;
            ownerR         <= '0;
            wdR            <= '0;
            grantR         <= '0;
            doneR          <= '0;
            errorR         <= 1'b0;
            resultR        <= '0;
            busyR          <= 1'b0;
            mulAR          <= '0;
            mulBR          <= '0;
            mulUnscaledR   <= 1'b0;
            mulInputReadyR <= 1'b0;
        end else begin
            doneR          <= '0;
            errorR         <= 1'b0;
            mulInputReadyR <= 1'b0;
            busyR          <= (nextStateS != sIdle);
            case (stateR)
                sIdle: begin
                    if (reqAnyS) begin
                        ownerR         <= pickS;
                        grantR         <= GRANT_LSB << pickS;
                        mulAR          <= bus.iA[int'(pickS) * WIDTH +: WIDTH];
                        mulBR          <= bus.iB[int'(pickS) * WIDTH +: WIDTH];
                        mulUnscaledR   <= bus.iUnscaled[pickS];
                        mulInputReadyR <= 1'b1;
                    end
                end
                sIssue: begin
                    wdR <= '0;
                end
                sWait: begin
                    // A reply in the last watchdog cycle still wins over the timeout.
                    if (bus.iMulOutputReady) begin
                        resultR <= bus.iMulR;
                        doneR   <= grantR;
                    end else if (wdExpiredS) begin
                        resultR <= '0;
                        doneR   <= grantR;
                        errorR  <= 1'b1;
                    end else begin
                        wdR <= wdR + WDW'(1);
                    end
                end
                sDone: begin
                    ptrR   <= rotIdx(ownerR, (IDXW + 1)'(1));
                    grantR <= '0;
                end
                default: begin
                    grantR <= '0;
                end
            endcase
        end
    end

    assign bus.oGrant         = grantR;
    assign bus.oDone          = doneR;
    assign bus.oError         = errorR;
    assign bus.oResult        = resultR;
    assign bus.oBusy          = busyR;
    assign bus.oMulA          = mulAR;
    assign bus.oMulB          = mulBR;
    assign bus.oMulUnscaled   = mulUnscaledR;
    assign bus.oMulInputReady = mulInputReadyR;
endmodule
